// File: rtl/axi_pkg.sv
// Shared types and helpers for the AXI4 result write master.
package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_WAIT_B
    } axi_wr_state_e;

    // Beats in the next burst: the remaining count, capped at the maximum burst length.
    function automatic logic [8:0] burst_beats(input logic [31:0] rem, input int unsigned max_len);
        logic [31:0] cap;
        cap = 32'(max_len);
        return (rem < cap) ? rem[8:0] : cap[8:0];
    endfunction

endpackage

// File: rtl/axi_wr_beat_fifo.sv
// Show-ahead synchronous beat FIFO with occupancy count; head is valid whenever not empty.
module axi_wr_beat_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // The read-credit scheme upstream must keep pushes away from a full FIFO.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/axi_data_wr_top.sv
// AXI4 write master: streams result BRAM beats into INCR bursts at res_ptr, counts B responses.
module axi_data_wr_top
    import axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH      = 64,
    parameter int AXI_DATA_WIDTH      = 128,
    parameter int AXI_XFER_SIZE_WIDTH = 32,
    parameter int BURST_LEN           = 16,
    parameter int RAM_DELAY           = 3,
    parameter int FIFO_DEPTH          = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_axiwr_start,
    output logic                          o_axiwr_done,
    output logic                          o_axiwr_err,
    input  logic [AXI_ADDR_WIDTH-1:0]     res_ptr,
    input  logic [AXI_XFER_SIZE_WIDTH-1:0] res_size_bytes,
    output logic                          o_bram_rden,
    output logic [31:0]                   o_bram_rdaddr,
    input  logic [AXI_DATA_WIDTH-1:0]     i_bram_rddata,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                          m_axi_wlast,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    input  logic [1:0]                    m_axi_bresp
);

    localparam int BPB     = AXI_DATA_WIDTH / 8;
    localparam int BPB_LOG = $clog2(BPB);
    localparam int BL_LOG  = $clog2(BURST_LEN);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(BURST_LEN * BPB);

    axi_wr_state_e state;
    axi_wr_state_e state_nxt;

    logic                      done;
    logic                      err;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]               total_beats;
    logic [31:0]               beats_read;
    logic [31:0]               rem_beats;
    logic [31:0]               bursts_total;
    logic [31:0]               bcount;
    logic [7:0]                awlen_q;
    logic [7:0]                beat_cnt;
    logic [RAM_DELAY-1:0]      vpipe;
    logic [CW-1:0]             inflight;
    logic [CW-1:0]             fifo_count;
    logic [CW:0]               credit;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic                      rden;
    logic                      start_ok;
    logic                      aw_fire;
    logic                      w_fire;
    logic                      b_fire;
    logic [32:0]               size_round;
    logic [32:0]               beats_round;
    logic [31:0]               total_calc;
    logic [31:0]               bursts_calc;
    logic [8:0]                next_len;

    assign size_round  = 33'(res_size_bytes) + 33'(BPB - 1);
    assign total_calc  = 32'(size_round >> BPB_LOG);
    assign beats_round = {1'b0, total_calc} + 33'(BURST_LEN - 1);
    assign bursts_calc = 32'(beats_round >> BL_LOG);
    assign next_len    = burst_beats(rem_beats, BURST_LEN);

    assign start_ok = i_axiwr_start && done;
    assign aw_fire  = m_axi_awvalid && m_axi_awready;
    assign w_fire   = m_axi_wvalid && m_axi_wready;
    assign b_fire   = m_axi_bvalid && m_axi_bready;

    // Read side runs ahead of the FSM, throttled so every outstanding read has a FIFO slot.
    assign credit = {1'b0, fifo_count} + {1'b0, inflight};
    assign rden   = !done && (beats_read < total_beats) && (credit < (CW+1)'(FIFO_DEPTH));
    assign push   = vpipe[RAM_DELAY-1];
    assign pop    = w_fire;

    assign o_axiwr_done  = done;
    assign o_axiwr_err   = err;
    assign o_bram_rden   = rden;
    assign o_bram_rdaddr = beats_read;
    assign m_axi_awvalid = (state == S_AW);
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = 8'(next_len - 9'd1);
    assign m_axi_wvalid  = (state == S_W) && !fifo_empty;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (beat_cnt == awlen_q);
    assign m_axi_bready  = !done;

    axi_wr_beat_fifo #(
        .WIDTH (AXI_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (i_bram_rddata),
        .pop       (pop),
        .head      (m_axi_wdata),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_ok) state_nxt = (total_calc == '0) ? S_WAIT_B : S_AW;
            S_AW:     if (m_axi_awready) state_nxt = S_W;
            S_W:      if (w_fire && m_axi_wlast) state_nxt = (rem_beats != '0) ? S_AW : S_WAIT_B;
            S_WAIT_B: if (bcount == bursts_total) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done         <= 1'b1;
            err          <= 1'b0;
            awaddr_q     <= '0;
            total_beats  <= '0;
            beats_read   <= '0;
            rem_beats    <= '0;
            bursts_total <= '0;
            bcount       <= '0;
            awlen_q      <= '0;
            beat_cnt     <= '0;
        end else begin
            if (start_ok) begin
                done         <= 1'b0;
                err          <= 1'b0;
                awaddr_q     <= res_ptr;
                total_beats  <= total_calc;
                rem_beats    <= total_calc;
                bursts_total <= bursts_calc;
                beats_read   <= '0;
                bcount       <= '0;
            end else begin
                if (state == S_WAIT_B && state_nxt == S_IDLE) done <= 1'b1;
                if (b_fire) begin
                    bcount <= bcount + 32'd1;
                    if (m_axi_bresp != AXI_RESP_OKAY) err <= 1'b1;
                end
                if (rden) beats_read <= beats_read + 32'd1;
            end
            if (aw_fire) begin
                rem_beats <= rem_beats - 32'(next_len);
                awlen_q   <= m_axi_awlen;
                awaddr_q  <= awaddr_q + BURST_BYTES;
                beat_cnt  <= '0;
            end else if (w_fire) begin
                beat_cnt  <= beat_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe    <= '0;
            inflight <= '0;
        end else begin
            vpipe <= (vpipe << 1) | RAM_DELAY'(rden);
            if (rden && !push) begin
                inflight <= inflight + CW'(1);
            end else if (!rden && push) begin
                inflight <= inflight - CW'(1);
            end
        end
    end

endmodule
